xout_window_acc: RTL and testbench



---
 rtl/xout_window_acc_if.sv | 29 ++
 rtl/xout_window_acc.sv | 90 +++++++++
 tb/tb_xout_window_acc.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/xout_window_acc_if.sv
// Handshake bundle between the XOUT producer, the window accumulator and the
// result consumer.
//   xin/xin_valid/xin_ready : sample stream into the accumulator
//   sum/sum_valid/sum_ready : window result stream out of the accumulator
//   ovf                     : result saturated, qualified by sum_valid
// modport slave  : the accumulator side
// modport master : the surrounding producer/consumer side
interface xout_window_acc_if #(
  parameter int unsigned NX   = 8,
  parameter int unsigned NACC = 16
);
  logic [NX-1:0]   xin;
  logic            xin_valid;
  logic            xin_ready;
  logic [NACC-1:0] sum;
  logic            sum_valid;
  logic            sum_ready;
  logic            ovf;

  modport slave (
    input  xin, xin_valid, sum_ready,
    output xin_ready, sum, sum_valid, ovf
  );

  modport master (
    output xin, xin_valid, sum_ready,
    input  xin_ready, sum, sum_valid, ovf
  );
endinterface

// File: rtl/xout_window_acc.sv
// Windowed saturating accumulator for the 8-bit XOUT stream.
// Accepts WINDOW unsigned samples over xin/xin_valid/xin_ready, sums them with
// clamping at 2^NACC-1, presents the result on sum/sum_valid/sum_ready with a
// sticky saturation flag ovf, then clears and starts the next window.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : xout_window_acc_if.slave (all registered outputs)
module xout_window_acc #(
  parameter int unsigned NX     = 8,
  parameter int unsigned WINDOW = 4,
  parameter int unsigned NACC   = 16
) (
  input logic               clk,
  input logic               rst,
  xout_window_acc_if.slave  bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state;
  logic [NACC-1:0] acc;
  logic [7:0]      cnt;
  logic            ovf_acc;

  logic            xin_ready_r;
  logic [NACC-1:0] sum_r;
  logic            sum_valid_r;
  logic            ovf_r;

  // One extra bit of headroom exposes the carry that triggers the clamp.
  logic [NACC:0]   raw;
  logic            clamp;
  logic [NACC-1:0] acc_next;

  always_comb begin
    raw      = {1'b0, acc} + {{(NACC+1-NX){1'b0}}, bus.xin};
    clamp    = raw[NACC];
    acc_next = clamp ? '1 : raw[NACC-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      ovf_acc     <= 1'b0;
      xin_ready_r <= 1'b0;
      sum_r       <= '0;
      sum_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // Also raises ready on the first edge after reset releases.
          xin_ready_r <= 1'b1;
          if (xin_ready_r && bus.xin_valid) begin
            if (cnt == 8'(WINDOW - 1)) begin
              sum_r       <= acc_next;
              ovf_r       <= ovf_acc | clamp;
              sum_valid_r <= 1'b1;
              xin_ready_r <= 1'b0;
              state       <= HOLD;
            end else begin
              acc     <= acc_next;
              cnt     <= cnt + 8'd1;
              ovf_acc <= ovf_acc | clamp;
            end
          end
        end
        HOLD: begin
          if (bus.sum_ready) begin
            sum_valid_r <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            ovf_acc     <= 1'b0;
            xin_ready_r <= 1'b1;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.xin_ready = xin_ready_r;
  assign bus.sum       = sum_r;
  assign bus.sum_valid = sum_valid_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_xout_window_acc.sv
// Drives three accumulator configurations with one shared stimulus stream:
//   d0: WINDOW=4 NACC=16, d1: WINDOW=4 NACC=9, d2: WINDOW=1 NACC=16.
// The reference keeps an unbounded integer total per window and clamps once
// at window end; the handshake is tracked as accumulate/hold phases.
module tb_xout_window_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xout_window_acc_if #(.NX(8), .NACC(16)) b0 ();
  xout_window_acc_if #(.NX(8), .NACC(9))  b1 ();
  xout_window_acc_if #(.NX(8), .NACC(16)) b2 ();

  xout_window_acc #(.NX(8), .WINDOW(4), .NACC(16)) d0 (.clk(clk), .rst(rst), .bus(b0));
  xout_window_acc #(.NX(8), .WINDOW(4), .NACC(9))  d1 (.clk(clk), .rst(rst), .bus(b1));
  xout_window_acc #(.NX(8), .WINDOW(1), .NACC(16)) d2 (.clk(clk), .rst(rst), .bus(b2));

  logic        o_rdy [3];
  logic        o_sv  [3];
  logic        o_ovf [3];
  logic [15:0] o_sum [3];

  assign o_rdy[0] = b0.xin_ready;  assign o_sv[0] = b0.sum_valid;
  assign o_rdy[1] = b1.xin_ready;  assign o_sv[1] = b1.sum_valid;
  assign o_rdy[2] = b2.xin_ready;  assign o_sv[2] = b2.sum_valid;
  assign o_ovf[0] = b0.ovf;        assign o_sum[0] = b0.sum;
  assign o_ovf[1] = b1.ovf;        assign o_sum[1] = {7'd0, b1.sum};
  assign o_ovf[2] = b2.ovf;        assign o_sum[2] = b2.sum;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  int unsigned win   [3];
  int unsigned maxv  [3];
  int unsigned total [3];
  int unsigned n     [3];
  bit          m_rdy [3];
  bit          m_sv  [3];
  bit          m_ovf [3];
  int unsigned m_sum [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      total[i] = 0; n[i] = 0; m_rdy[i] = 0; m_sv[i] = 0; m_ovf[i] = 0; m_sum[i] = 0;
    end
  endtask

  task automatic check_all(input bit in_reset);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d_xin_ready", i), 32'(o_rdy[i]), 32'(m_rdy[i]));
      check($sformatf("d%0d_sum_valid", i), 32'(o_sv[i]), 32'(m_sv[i]));
      check($sformatf("d%0d_sum", i), 32'(o_sum[i]), m_sum[i]);
      if (m_sv[i] || in_reset)
        check($sformatf("d%0d_ovf", i), 32'(o_ovf[i]), 32'(m_ovf[i]));
    end
  endtask

  // One clock: apply inputs, advance the reference across the coming edge,
  // then compare on the falling edge.
  task automatic step(input bit v, input logic [7:0] x, input bit r);
    b0.xin_valid = v; b1.xin_valid = v; b2.xin_valid = v;
    b0.xin = x;       b1.xin = x;       b2.xin = x;
    b0.sum_ready = r; b1.sum_ready = r; b2.sum_ready = r;
    for (int i = 0; i < 3; i++) begin
      if (m_sv[i]) begin
        if (r) begin
          m_sv[i] = 0; m_rdy[i] = 1;
        end
      end else if (!m_rdy[i]) begin
        m_rdy[i] = 1;
      end else if (v) begin
        total[i] += x;
        n[i]++;
        if (n[i] == win[i]) begin
          m_sum[i] = (total[i] > maxv[i]) ? maxv[i] : total[i];
          m_ovf[i] = (total[i] > maxv[i]);
          m_sv[i]  = 1; m_rdy[i] = 0;
          total[i] = 0; n[i] = 0;
        end
      end
    end
    @(negedge clk);
    check_all(1'b0);
  endtask

  // Asynchronous reset asserted just after a falling edge, held over one
  // rising edge, released on the next falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all(1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all(1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) step(1'b0, 8'd0, 1'b1);
  endtask

  initial begin
    win[0] = 4; win[1] = 4; win[2] = 1;
    maxv[0] = 65535; maxv[1] = 511; maxv[2] = 65535;
    model_reset();
    b0.xin_valid = 0; b1.xin_valid = 0; b2.xin_valid = 0;
    b0.xin = 0; b1.xin = 0; b2.xin = 0;
    b0.sum_ready = 0; b1.sum_ready = 0; b2.sum_ready = 0;

    @(negedge clk);
    do_reset();

    // Basic window 1,2,3,4 with sum_ready high.
    step(1'b0, 8'd0, 1'b1);
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b1);
    drain();

    // Gapped input 5,_,7,_,_,9,11 then backpressure, stray 255 during hold.
    do_reset();
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd5, 1'b0);  step(1'b0, 8'd0, 1'b0);  step(1'b1, 8'd7, 1'b0);
    step(1'b0, 8'd0, 1'b0);  step(1'b0, 8'd0, 1'b0);  step(1'b1, 8'd9, 1'b0);
    step(1'b1, 8'd11, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 8'd255, 1'b0);
    drain();

    // Saturation 200,200,200,0 then 1,1,1,1.
    do_reset();
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd200, 1'b1); step(1'b1, 8'd200, 1'b1);
    step(1'b1, 8'd200, 1'b1); step(1'b1, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 8'd1, 1'b1);
    drain();

    // Reset mid-window, stray sum_ready while idle, then 1,2,3,4.
    do_reset();
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd50, 1'b1); step(1'b1, 8'd60, 1'b0);
    do_reset();
    step(1'b0, 8'd0, 1'b1);
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b1);
    drain();

    // Window-1 stream 9,8,7.
    step(1'b1, 8'd9, 1'b1); step(1'b1, 8'd8, 1'b1); step(1'b1, 8'd7, 1'b1);
    drain();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        logic [7:0] x;
        x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom);
        step($urandom_range(0, 3) != 0, x, $urandom_range(0, 2) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
